// File: rtl/control_sequencer_if.sv
// Datapath-facing bundle of the control sequencer: instruction/handshake inputs and all strobes.
// Build option CONTROL_SEQ_STEP_EN adds the single-step qualifier "step".
interface control_sequencer_if #(
    parameter int NREG = 16,
    parameter int OPW  = 5
);
    logic            run;
    logic [31:0]     ir;
    logic            mem_rdy;
`ifdef CONTROL_SEQ_STEP_EN
    logic            step;
`endif
    logic            PC_out, MDR_out, Zlo_out, Zhi_out;
    logic            MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd;
    logic            IncPC, Read;
    logic [NREG-1:0] R_rd, R_wrt;
    logic [OPW-1:0]  op_sel;
    logic            busy, halted, illegal;

    modport master (
        input  run, ir, mem_rdy,
`ifdef CONTROL_SEQ_STEP_EN
        input  step,
`endif
        output PC_out, MDR_out, Zlo_out, Zhi_out,
        output MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd,
        output IncPC, Read, R_rd, R_wrt, op_sel, busy, halted, illegal
    );

    modport slave (
        output run, ir, mem_rdy,
`ifdef CONTROL_SEQ_STEP_EN
        output step,
`endif
        input  PC_out, MDR_out, Zlo_out, Zhi_out,
        input  MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd,
        input  IncPC, Read, R_rd, R_wrt, op_sel, busy, halted, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer (T0..T6) with Moore-decoded datapath strobes.
// Build option CONTROL_SEQ_STEP_EN: T-states advance (and strobe) only when step=1.
module control_sequencer #(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input logic                 clk,
    input logic                 clr,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    localparam logic [4:0] OP_NEG  = 5'b01001;
    localparam logic [4:0] OP_NOT  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01100;
    localparam logic [4:0] OP_DIV  = 5'b01101;
    localparam logic [4:0] OP_HALT = 5'b11111;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   advance;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_muldiv, is_unary;
    logic       unused_ir;

    assign op        = bus.ir[31:27];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign unused_ir = ^bus.ir[14:0];

    assign is_alu    = (op <= OP_NOT);
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    assign is_unary  = (op == OP_NEG) || (op == OP_NOT);

`ifdef CONTROL_SEQ_STEP_EN
    assign advance = bus.step;
`else
    assign advance = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        bus.PC_out  = 1'b0;
        bus.MDR_out = 1'b0;
        bus.Zlo_out = 1'b0;
        bus.Zhi_out = 1'b0;
        bus.MAR_rd  = 1'b0;
        bus.MDR_rd  = 1'b0;
        bus.IR_rd   = 1'b0;
        bus.Y_rd    = 1'b0;
        bus.Zlo_rd  = 1'b0;
        bus.Zhi_rd  = 1'b0;
        bus.HI_rd   = 1'b0;
        bus.LO_rd   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.R_rd    = '0;
        bus.R_wrt   = '0;
        bus.op_sel  = '0;

        unique case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0: if (advance) begin
                bus.PC_out = 1'b1;
                bus.MAR_rd = 1'b1;
                bus.IncPC  = 1'b1;
                state_d    = S_T1;
            end
            S_T1: if (advance) begin
                bus.Read   = 1'b1;
                bus.MDR_rd = 1'b1;
                if (bus.mem_rdy) state_d = S_T2;
            end
            S_T2: if (advance) begin
                bus.MDR_out = 1'b1;
                bus.IR_rd   = 1'b1;
                if (is_alu || is_muldiv) begin
                    state_d = S_T3;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = (op != OP_HALT);
                end
            end
            S_T3: if (advance) begin
                bus.R_wrt = NREG'(1) << rb;
                bus.Y_rd  = 1'b1;
                state_d   = S_T4;
            end
            S_T4: if (advance) begin
                bus.R_wrt  = NREG'(1) << (is_unary ? rb : rc);
                bus.op_sel = OPW'(op);
                bus.Zlo_rd = 1'b1;
                bus.Zhi_rd = is_muldiv;
                state_d    = S_T5;
            end
            S_T5: if (advance) begin
                bus.Zlo_out = 1'b1;
                if (is_muldiv) begin
                    bus.LO_rd = 1'b1;
                    state_d   = S_T6;
                end else begin
                    bus.R_rd  = NREG'(1) << ra;
                    state_d   = S_T0;
                end
            end
            S_T6: if (advance) begin
                bus.Zhi_out = 1'b1;
                bus.HI_rd   = 1'b1;
                state_d     = S_T0;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.halted  = (state_q == S_HALT);
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: a per-instruction phase model builds the expected strobe trace cycle by cycle.
// Random instruction mix, wait states and run/mem_rdy noise; directed halt, illegal and abort cases.
module tb_control_sequencer;
    typedef struct packed {
        logic        pc_out, mdr_out, zlo_out, zhi_out;
        logic        mar_rd, mdr_rd, ir_rd, y_rd, zlo_rd, zhi_rd, hi_rd, lo_rd;
        logic        inc_pc, read;
        logic [15:0] r_rd, r_wrt;
        logic [4:0]  op_sel;
        logic        busy, halted, illegal;
    } out_t;

    typedef struct {
        out_t        exp;
        logic        run, rdy, clr;
        bit          chk;
        logic [31:0] ir;
        string       tag;
    } item_t;

    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   bad   = 0;

    item_t       q[$];
    logic [31:0] cur_ir = '0;

    control_sequencer_if #(.NREG(16), .OPW(5)) bus ();
    control_sequencer #(.NREG(16), .OPW(5)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

`ifdef CONTROL_SEQ_STEP_EN
    initial bus.step = 1'b1;
`endif

    function automatic out_t sample();
        out_t o;
        o.pc_out  = bus.PC_out;   o.mdr_out = bus.MDR_out;
        o.zlo_out = bus.Zlo_out;  o.zhi_out = bus.Zhi_out;
        o.mar_rd  = bus.MAR_rd;   o.mdr_rd  = bus.MDR_rd;
        o.ir_rd   = bus.IR_rd;    o.y_rd    = bus.Y_rd;
        o.zlo_rd  = bus.Zlo_rd;   o.zhi_rd  = bus.Zhi_rd;
        o.hi_rd   = bus.HI_rd;    o.lo_rd   = bus.LO_rd;
        o.inc_pc  = bus.IncPC;    o.read    = bus.Read;
        o.r_rd    = bus.R_rd;     o.r_wrt   = bus.R_wrt;
        o.op_sel  = bus.op_sel;   o.busy    = bus.busy;
        o.halted  = bus.halted;   o.illegal = bus.illegal;
        return o;
    endfunction

    function automatic void push(out_t e, logic run, logic rdy, logic c, bit chk, string tag);
        item_t it;
        it.exp = e; it.run = run; it.rdy = rdy; it.clr = c;
        it.chk = chk; it.ir = cur_ir; it.tag = tag;
        q.push_back(it);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Reference: one instruction expands into fetch phases plus its execute phases.
    function automatic void add_instr(logic [31:0] ir, int waits);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit         md, un, legal;
        out_t       e;
        cur_ir = ir;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        md    = (op == 5'd12) || (op == 5'd13);
        un    = (op == 5'd9) || (op == 5'd10);
        legal = (op <= 5'd10) || md;

        e = '0; e.busy = 1; e.pc_out = 1; e.mar_rd = 1; e.inc_pc = 1;
        push(e, rbit(), rbit(), 0, 1, "T0");
        for (int k = 0; k <= waits; k++) begin
            e = '0; e.busy = 1; e.read = 1; e.mdr_rd = 1;
            push(e, rbit(), (k == waits), 0, 1, "T1");
        end
        e = '0; e.busy = 1; e.mdr_out = 1; e.ir_rd = 1;
        push(e, rbit(), rbit(), 0, 1, "T2");
        if (!legal) return;

        e = '0; e.busy = 1; e.r_wrt = 16'(1) << rb; e.y_rd = 1;
        push(e, rbit(), rbit(), 0, 1, "T3");
        e = '0; e.busy = 1; e.r_wrt = 16'(1) << (un ? rb : rc);
        e.op_sel = op; e.zlo_rd = 1; e.zhi_rd = md;
        push(e, rbit(), rbit(), 0, 1, "T4");
        e = '0; e.busy = 1; e.zlo_out = 1;
        if (md) e.lo_rd = 1; else e.r_rd = 16'(1) << ra;
        push(e, rbit(), rbit(), 0, 1, "T5");
        if (md) begin
            e = '0; e.busy = 1; e.zhi_out = 1; e.hi_rd = 1;
            push(e, rbit(), rbit(), 0, 1, "T6");
        end
    endfunction

    function automatic void add_halt(int n, logic ill);
        out_t e;
        e = '0; e.halted = 1; e.illegal = ill;
        for (int k = 0; k < n; k++) push(e, rbit(), rbit(), 0, 1, "HALT");
    endfunction

    function automatic void add_clr_and_start();
        push('0, 0, 0, 1, 0, "clr");
        push('0, 1, 0, 0, 1, "IDLE_run");
    endfunction

    task automatic apply(input item_t it, output out_t act);
        bus.run = it.run; bus.ir = it.ir; bus.mem_rdy = it.rdy; clr = it.clr;
        @(negedge clk);
        act = sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        item_t it; out_t act;
        push('0, 1, 1, 1, 0, "clr_first");
        push('0, 1, 1, 1, 1, "clr_idle");
        push('0, 0, 1, 0, 1, "idle_hold");
        push('0, 0, 0, 0, 1, "idle_hold");
        while (q.size() > 0) begin
            it = q.pop_front();
            apply(it, act);
            if (it.chk) begin
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL reset/%s: got %h want %h", it.tag, act, it.exp);
                end
            end
        end
    endtask

    task automatic test_alu();
        item_t it; out_t act;
        add_clr_and_start();
        add_instr(32'h021B8000, 0);
        add_instr(32'h4C9F8000, 0);
        add_instr(32'h5160_0000, 1);
        add_instr(32'hF8000000, 0);
        add_halt(2, 0);
        while (q.size() > 0) begin
            it = q.pop_front();
            apply(it, act);
            if (it.chk) begin
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL alu/%s: got %h want %h", it.tag, act, it.exp);
                end
            end
        end
    endtask

    task automatic test_muldiv();
        item_t it; out_t act;
        add_clr_and_start();
        add_instr(32'h601B8000, 0);
        add_instr(32'h6ED08000, 0);
        add_instr(32'hF8000000, 0);
        add_halt(2, 0);
        while (q.size() > 0) begin
            it = q.pop_front();
            apply(it, act);
            if (it.chk) begin
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL muldiv/%s: got %h want %h", it.tag, act, it.exp);
                end
            end
        end
    endtask

    task automatic test_wait();
        item_t it; out_t act;
        add_clr_and_start();
        add_instr(32'h021B8000, 3);
        add_instr(32'h601B8000, 2);
        add_instr(32'hF8000000, 1);
        add_halt(1, 0);
        while (q.size() > 0) begin
            it = q.pop_front();
            apply(it, act);
            if (it.chk) begin
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL wait/%s: got %h want %h", it.tag, act, it.exp);
                end
            end
        end
    endtask

    task automatic test_halt();
        item_t it; out_t act; out_t e;
        add_clr_and_start();
        add_instr(32'hF8000000, 0);
        add_halt(3, 0);
        push('{default: '0, halted: 1'b1}, 1, 1, 0, 1, "HALT_run");
        e = '0; e.halted = 1;
        push(e, 1, 0, 1, 1, "HALT_clr");
        push('0, 0, 0, 0, 1, "IDLE_after_halt");
        push('0, 0, 0, 0, 1, "IDLE_after_halt");
        while (q.size() > 0) begin
            it = q.pop_front();
            apply(it, act);
            if (it.chk) begin
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL halt/%s: got %h want %h", it.tag, act, it.exp);
                end
            end
        end
    endtask

    task automatic test_illegal();
        item_t it; out_t act; out_t e;
        logic [4:0] op; logic [31:0] r; int pick;
        for (int n = 0; n < 4; n++) begin
            if (n == 0) begin
                r = 32'h80000000;
            end else begin
                pick = $urandom_range(0, 17);
                op = (pick == 0) ? 5'd11 : 5'(13 + pick);
                r = $urandom();
                r[31:27] = op;
            end
            add_clr_and_start();
            add_instr(r, $urandom_range(0, 2));
            add_halt(3, 1);
            e = '0; e.halted = 1; e.illegal = 1;
            push(e, 1, 0, 1, 1, "ILL_clr");
            push('0, 0, 0, 0, 1, "IDLE_ill_cleared");
        end
        while (q.size() > 0) begin
            it = q.pop_front();
            apply(it, act);
            if (it.chk) begin
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL illegal/%s: got %h want %h", it.tag, act, it.exp);
                end
            end
        end
    endtask

    task automatic test_abort();
        item_t it; out_t act;
        add_clr_and_start();
        add_instr(32'h021B8000, 0);
        void'(q.pop_back());
        it = q.pop_back();
        it.clr = 1;
        q.push_back(it);
        push('0, 0, 1, 0, 1, "IDLE_after_abort");
        push('0, 0, 1, 0, 1, "IDLE_after_abort");
        push('0, 0, 0, 0, 1, "IDLE_after_abort");
        while (q.size() > 0) begin
            it = q.pop_front();
            apply(it, act);
            if (it.chk) begin
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL abort/%s: got %h want %h", it.tag, act, it.exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        item_t it; out_t act;
        logic [31:0] r; int pick;
        add_clr_and_start();
        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 12);
            r = $urandom();
            r[31:27] = (pick <= 10) ? 5'(pick) : 5'(pick + 1);
            add_instr(r, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
        r = $urandom();
        r[31:27] = 5'b11111;
        add_instr(r, 0);
        add_halt(2, 0);
        while (q.size() > 0) begin
            it = q.pop_front();
            apply(it, act);
            if (it.chk) begin
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL b2b/%s: got %h want %h", it.tag, act, it.exp);
                end
            end
        end
    endtask

    initial begin
        clr = 1'b1; bus.run = 1'b0; bus.ir = '0; bus.mem_rdy = 1'b0;
        test_reset();
        test_alu();
        test_muldiv();
        test_wait();
        test_halt();
        test_illegal();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
